// File: rtl/video_stream_gen.sv
// Video stream transmitter: programmable frame geometry, blanking, optional
// de spacing and selectable test patterns on a registered de/hs/vs/do_o stream.
module video_stream_gen #(
  parameter int unsigned DATA_WIDTH  = 12,
  parameter int unsigned DE_O_PERIOD = 0,
  parameter int unsigned PIX_W       = 12,
  parameter int unsigned LINE_W      = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [1:0]            pattern_sel,
  input  logic [DATA_WIDTH-1:0] cfg_const,
  input  logic [PIX_W-1:0]      cfg_pix_count,
  input  logic [LINE_W-1:0]     cfg_line_count,
  input  logic [PIX_W-1:0]      cfg_hblank,
  input  logic [LINE_W-1:0]     cfg_vblank,
  output logic [DATA_WIDTH-1:0] do_o,
  output logic                  de_o,
  output logic                  hs_o,
  output logic                  vs_o,
  output logic                  frame_done
);

  localparam int unsigned PER   = (DE_O_PERIOD == 0) ? 1 : DE_O_PERIOD;
  localparam int unsigned PH_W  = (PER > 1) ? $clog2(PER) : 1;
  localparam int unsigned CNT_W = (PIX_W > LINE_W) ? PIX_W : LINE_W;

  typedef enum logic [2:0] {
    S_IDLE, S_VS_LEAD, S_LINE, S_HBLANK, S_VBLANK
  } state_t;

  state_t r_state, w_nxt_state;

  logic [CNT_W-1:0]      r_cnt;
  logic [PH_W-1:0]       r_ph;
  logic [PIX_W-1:0]      r_x;
  logic [LINE_W-1:0]     r_y;
  logic [PIX_W-1:0]      r_pix_last;
  logic [LINE_W-1:0]     r_line_last;
  logic [CNT_W-1:0]      r_hb_last;
  logic [CNT_W-1:0]      r_vb_last;
  logic [1:0]            r_pat;
  logic [DATA_WIDTH-1:0] r_const;

  logic                  w_ph_last, w_line_end, w_hb_end, w_vb_end, w_start;
  logic                  w_vs, w_hs, w_de, w_done;
  logic [DATA_WIDTH-1:0] w_pix;

  // Terminal-count decodes; a line ends on the last phase of its last pixel
  assign w_ph_last  = (r_ph == PH_W'(PER - 1));
  assign w_line_end = w_ph_last && (r_x == r_pix_last);
  assign w_hb_end   = (r_cnt == r_hb_last);
  assign w_vb_end   = (r_cnt == r_vb_last);
  assign w_start    = (w_nxt_state == S_VS_LEAD) &&
                      ((r_state == S_IDLE) || (r_state == S_VBLANK));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt_state;
  end

  // Next-state logic
  always_comb begin
    w_nxt_state = r_state;
    unique case (r_state)
      S_IDLE:    if (enable) w_nxt_state = S_VS_LEAD;
      S_VS_LEAD: if (w_hb_end) w_nxt_state = S_LINE;
      S_LINE:    if (w_line_end) w_nxt_state = S_HBLANK;
      S_HBLANK:  if (w_hb_end) w_nxt_state = (r_y == r_line_last) ? S_VBLANK : S_LINE;
      S_VBLANK:  if (w_vb_end) w_nxt_state = enable ? S_VS_LEAD : S_IDLE;
      default:   w_nxt_state = S_IDLE;
    endcase
  end

  // Output decode for the next registered output values
  always_comb begin
    w_vs   = 1'b0;
    w_hs   = 1'b1;
    w_de   = 1'b0;
    w_done = 1'b0;
    w_pix  = '0;
    unique case (r_state)
      S_VS_LEAD, S_HBLANK: w_vs = 1'b1;
      S_LINE: begin
        w_vs = 1'b1;
        w_hs = 1'b0;
        w_de = (r_ph == '0);
      end
      S_VBLANK: w_done = w_vb_end;
      default: ;
    endcase
    unique case (r_pat)
      2'd0:    w_pix = DATA_WIDTH'(r_x);
      2'd1:    w_pix = DATA_WIDTH'(r_y);
      2'd2:    w_pix = DATA_WIDTH'(r_x) + DATA_WIDTH'(r_y);
      default: w_pix = r_const;
    endcase
  end

  // Registered outputs; pixel data holds while de is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      do_o       <= '0;
      de_o       <= 1'b0;
      hs_o       <= 1'b1;
      vs_o       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      de_o       <= w_de;
      hs_o       <= w_hs;
      vs_o       <= w_vs;
      frame_done <= w_done;
      if (w_de) do_o <= w_pix;
    end
  end

  // Blanking cycle counter, de phase, pixel and line indices
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_ph  <= '0;
      r_x   <= '0;
      r_y   <= '0;
    end else begin
      if (w_nxt_state != r_state) r_cnt <= '0;
      else if (r_state != S_IDLE && r_state != S_LINE) r_cnt <= r_cnt + CNT_W'(1);

      if (r_state == S_LINE && !w_ph_last) r_ph <= r_ph + PH_W'(1);
      else                                 r_ph <= '0;

      if (r_state != S_LINE || w_line_end) r_x <= '0;
      else if (w_ph_last)                  r_x <= r_x + PIX_W'(1);

      if (w_start) r_y <= '0;
      else if (r_state == S_HBLANK && w_nxt_state == S_LINE) r_y <= r_y + LINE_W'(1);
    end
  end

  // Frame configuration latch; zero-valued fields behave as one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix_last  <= '0;
      r_line_last <= '0;
      r_hb_last   <= '0;
      r_vb_last   <= '0;
      r_pat       <= '0;
      r_const     <= '0;
    end else if (w_start) begin
      r_pix_last  <= (cfg_pix_count == '0)  ? '0 : cfg_pix_count - PIX_W'(1);
      r_line_last <= (cfg_line_count == '0) ? '0 : cfg_line_count - LINE_W'(1);
      r_hb_last   <= (cfg_hblank == '0)     ? '0 : CNT_W'(cfg_hblank - PIX_W'(1));
      r_vb_last   <= (cfg_vblank == '0)     ? '0 : CNT_W'(cfg_vblank - LINE_W'(1));
      r_pat       <= pattern_sel;
      r_const     <= cfg_const;
    end
  end

endmodule

// File: tb/tb_video_stream_gen.sv
// Bench for video_stream_gen: two instances (12-bit/P=1 and 4-bit/P=4) driven
// with fixed and random frame configs, compared per cycle to a frame model.
module tb_video_stream_gen;

  typedef struct {
    int pix; int lines; int hb; int vb; int pat; int cst;
  } cfg_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  en;
  logic [1:0]  pattern_sel;
  logic [11:0] cfg_const, cfg_pix_count, cfg_line_count, cfg_hblank, cfg_vblank;

  logic [11:0] do0;
  logic        de0, hs0, vs0, fd0;
  logic [3:0]  do1;
  logic        de1, hs1, vs1, fd1;

  int n_checks = 0;
  int n_fail   = 0;
  int last_do[2];

  int   g_inst, g_idx, g_drop_at, g_abort_at;
  bit   g_aborted;
  int   g_vs_cnt, g_de_cnt, g_done_cnt;
  cfg_t g_next;

  always #5 clk = ~clk;

  video_stream_gen #(.DATA_WIDTH(12), .DE_O_PERIOD(0), .PIX_W(12), .LINE_W(12)) u_dut0 (
    .clk(clk), .rst(rst), .enable(en[0]), .pattern_sel(pattern_sel),
    .cfg_const(cfg_const), .cfg_pix_count(cfg_pix_count),
    .cfg_line_count(cfg_line_count), .cfg_hblank(cfg_hblank),
    .cfg_vblank(cfg_vblank), .do_o(do0), .de_o(de0), .hs_o(hs0),
    .vs_o(vs0), .frame_done(fd0)
  );

  video_stream_gen #(.DATA_WIDTH(4), .DE_O_PERIOD(4), .PIX_W(12), .LINE_W(12)) u_dut1 (
    .clk(clk), .rst(rst), .enable(en[1]), .pattern_sel(pattern_sel),
    .cfg_const(cfg_const[3:0]), .cfg_pix_count(cfg_pix_count),
    .cfg_line_count(cfg_line_count), .cfg_hblank(cfg_hblank),
    .cfg_vblank(cfg_vblank), .do_o(do1), .de_o(de1), .hs_o(hs1),
    .vs_o(vs1), .frame_done(fd1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d idx=%0d got=%h exp=%h t=%0t", tag, g_inst, g_idx, got, exp, $time);
    end
  endtask

  // {vs, hs, de, frame_done, data}
  function automatic logic [15:0] obs(input int inst);
    if (inst == 0) return {vs0, hs0, de0, fd0, do0};
    return {vs1, hs1, de1, fd1, 8'h00, do1};
  endfunction

  function automatic logic [15:0] mk(input bit vs, input bit hs, input bit de, input bit dn, input int d);
    return {vs, hs, de, dn, 12'(d)};
  endfunction

  function automatic int patv(input int pat, input int x, input int y, input int cst, input int dw);
    int v;
    case (pat)
      0: v = x;
      1: v = y;
      2: v = x + y;
      default: v = cst;
    endcase
    return v & ((1 << dw) - 1);
  endfunction

  function automatic cfg_t mkcfg(input int pix, input int lines, input int hb, input int vb,
                                 input int pat, input int cst);
    cfg_t c;
    c.pix = pix; c.lines = lines; c.hb = hb; c.vb = vb; c.pat = pat; c.cst = cst;
    return c;
  endfunction

  function automatic cfg_t rand_cfg();
    return mkcfg(int'($urandom_range(0, 10)), int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)));
  endfunction

  task automatic apply_cfg(input cfg_t c);
    cfg_pix_count  = 12'(c.pix);
    cfg_line_count = 12'(c.lines);
    cfg_hblank     = 12'(c.hb);
    cfg_vblank     = 12'(c.vb);
    pattern_sel    = 2'(c.pat);
    cfg_const      = 12'(c.cst);
  endtask

  // One expected output cycle: compare, then perform any scheduled mid-frame action
  task automatic step(input logic [15:0] e);
    logic [15:0] o;
    if (g_aborted) return;
    o = obs(g_inst);
    check_eq("frame_cycle", 32'(o), 32'(e));
    if (o[15]) g_vs_cnt++;
    if (o[13]) g_de_cnt++;
    if (o[12]) g_done_cnt++;
    if (g_idx == 1) apply_cfg(g_next);
    if (g_idx == g_drop_at) en[g_inst] = 1'b0;
    if (g_idx == g_abort_at) begin
      #1 rst = 1'b1;
      #1;
      check_eq("rst_async", 32'(obs(g_inst)), 32'(mk(0, 1, 0, 0, 0)));
      g_aborted = 1'b1;
      last_do[0] = 0;
      last_do[1] = 0;
      return;
    end
    @(negedge clk);
    g_idx++;
  endtask

  // Expected frame built from the config: lead blank, lines, vblank
  task automatic check_frame(input int inst, input cfg_t c, input cfg_t nxt, input bit wait_vs,
                             input int drop_at, input int abort_at);
    int pix, nl, hb, vb, p, dw, d;
    bit found;
    logic [15:0] o;
    g_inst = inst; g_next = nxt; g_drop_at = drop_at; g_abort_at = abort_at;
    g_aborted = 1'b0; g_idx = 0; g_vs_cnt = 0; g_de_cnt = 0; g_done_cnt = 0;
    p   = (inst == 0) ? 1 : 4;
    dw  = (inst == 0) ? 12 : 4;
    pix = (c.pix == 0) ? 1 : c.pix;
    nl  = (c.lines == 0) ? 1 : c.lines;
    hb  = (c.hb == 0) ? 1 : c.hb;
    vb  = (c.vb == 0) ? 1 : c.vb;
    if (wait_vs) begin
      found = 1'b0;
      for (int t = 0; t < 200; t++) begin
        o = obs(inst);
        if (o[15]) begin found = 1'b1; break; end
        @(negedge clk);
      end
      if (!found) begin
        check_eq("vs_start_timeout", 32'(0), 32'(1));
        return;
      end
    end
    for (int k = 0; k < hb; k++) step(mk(1, 1, 0, 0, last_do[inst]));
    for (int y = 0; y < nl; y++) begin
      for (int k = 0; k < pix * p; k++) begin
        if (k % p == 0) begin
          d = patv(c.pat, k / p, y, c.cst, dw);
          if (!g_aborted) last_do[inst] = d;
          step(mk(1, 0, 1, 0, d));
        end else begin
          step(mk(1, 0, 0, 0, last_do[inst]));
        end
      end
      for (int k = 0; k < hb; k++) step(mk(1, 1, 0, 0, last_do[inst]));
    end
    for (int k = 0; k < vb; k++) step(mk(0, 1, 0, (k == vb - 1), last_do[inst]));
    if (!g_aborted) begin
      check_eq("vs_len", 32'(g_vs_cnt), 32'(hb + nl * (pix * p + hb)));
      check_eq("de_cnt", 32'(g_de_cnt), 32'(pix * nl));
      check_eq("done_cnt", 32'(g_done_cnt), 32'(1));
    end
  endtask

  task automatic idle_check(input int inst, input int n);
    g_inst = inst;
    for (int k = 0; k < n; k++) begin
      check_eq("idle", 32'(obs(inst)), 32'(mk(0, 1, 0, 0, last_do[inst])));
      @(negedge clk);
    end
  endtask

  initial begin
    cfg_t a, cur, n, dcfg, e, f, g;
    rst = 1'b1;
    en  = 2'b00;
    last_do[0] = 0;
    last_do[1] = 0;
    a = mkcfg(8, 4, 3, 2, 0, 0);
    apply_cfg(a);
    repeat (2) @(negedge clk);
    check_eq("reset_state0", 32'(obs(0)), 32'(mk(0, 1, 0, 0, 0)));
    check_eq("reset_state1", 32'(obs(1)), 32'(mk(0, 1, 0, 0, 0)));
    rst = 1'b0;
    idle_check(0, 3);
    idle_check(1, 1);

    // 12-bit, one de per clock: basic frame then back-to-back random frames
    en[0] = 1'b1;
    cur = rand_cfg();
    check_frame(0, a, cur, 1'b1, -1, -1);
    for (int k = 0; k < 5; k++) begin
      n = rand_cfg();
      if (k == 1) n.lines = 0;
      if (k == 3) begin n.pix = 0; n.hb = 0; n.vb = 0; end
      check_frame(0, cur, n, 1'b0, -1, -1);
      cur = n;
    end
    dcfg = mkcfg(8, 4, 3, 2, 2, 0);
    check_frame(0, cur, dcfg, 1'b0, -1, -1);
    // enable dropped in the second line: frame completes, then idle
    check_frame(0, dcfg, dcfg, 1'b0, 3 + 11 + 2, -1);
    idle_check(0, 6);

    // asynchronous reset inside the first line, then a clean frame
    en[0] = 1'b1;
    e = mkcfg(6, 2, 2, 3, 3, 12'hA5C);
    check_frame(0, dcfg, e, 1'b1, -1, 5);
    @(negedge clk);
    rst = 1'b0;
    check_frame(0, e, e, 1'b1, 2, -1);
    idle_check(0, 4);

    // 4-bit data, de every 4th clock
    f = mkcfg(5, 2, 3, 2, 0, 0);
    g = mkcfg(12, 10, 2, 1, 2, 0);
    apply_cfg(f);
    en[1] = 1'b1;
    check_frame(1, f, g, 1'b1, -1, -1);
    cur = rand_cfg();
    check_frame(1, g, cur, 1'b0, -1, -1);
    for (int k = 0; k < 3; k++) begin
      n = rand_cfg();
      check_frame(1, cur, n, 1'b0, (k == 2) ? 2 : -1, -1);
      cur = n;
    end
    idle_check(1, 5);
    idle_check(0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
